ram_bus_bridge: RTL
===================

# ram_bus_bridge

Converts the core's single-cycle data-RAM port (`ram_en`, `ram_write_en`, `ram_addr`, `ram_write_data`, `ram_read_data`) into a split-handshake SRAM-like bus with separate address and data acknowledges. It drives the core's global `stall` input for as long as an access is outstanding. It sits directly downstream of the core's MEM stage, between the core and the data-side bus/interconnect. A timeout counter guarantees forward progress if the slave never answers.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent waiting in REQ+WAIT before forced completion; legal range 1–65535.
- `ERR_DATA`, default 32'hDEADBEEF: read data returned on timeout.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ram_en`  in  1  core access request; the core holds it stable while `stall`=1.
- `ram_write_en`  in  4  byte strobes; 0 means read.
- `ram_addr`  in  32  byte address.
- `ram_write_data`  in  32  store data, byte-lane aligned.
- `ram_read_data`  out  32  registered read data.
- `stall`  out  1  to the core's `stall` input.
- `bus_req`  out  1  request valid.
- `bus_wr`  out  1  1 = write.
- `bus_size`  out  2  0 = byte, 1 = half, 2 = word.
- `bus_wstrb`  out  4  = `ram_write_en`.
- `bus_addr`  out  32  request address.
- `bus_wdata`  out  32  = `ram_write_data`.
- `bus_addr_ok`  in  1  request accepted this cycle (valid only while `bus_req`=1).
- `bus_data_ok`  in  1  response (read data or write ack) this cycle.
- `bus_rdata`  in  32  read data, valid with `bus_data_ok`.
- `bus_error`  out  1  one-cycle pulse on timeout completion.

## Operation
- States: IDLE, REQ (request presented, awaiting `bus_addr_ok`), WAIT (accepted, awaiting `bus_data_ok`), DONE (one-cycle completion).
- IDLE:
  - `ram_en`=0: stay in IDLE.
  - `ram_en`=1: `bus_req`=1 in the same cycle (combinational).
  - `addr_ok`=0: go to REQ.
  - `addr_ok`=1 and `data_ok`=0: go to WAIT.
  - `addr_ok`=1 and `data_ok`=1: go to DONE.
- REQ: `bus_req`=1; same `addr_ok`/`data_ok` decision as IDLE.
- WAIT: `bus_req`=0; go to DONE on `data_ok`.
- DONE: `bus_req`=0; go unconditionally to IDLE.
- DONE always passes through IDLE. Back-to-back core accesses therefore see IDLE again and issue a fresh request.
- `stall` = `ram_en` & (state != DONE). DONE is the only cycle the core advances past a memory access.
- Reads: `bus_wr`=0, `bus_size`=2, `bus_addr` = {`ram_addr`[31:2], 2'b00}. The core's WB stage extracts sub-word data.
- Writes: `bus_wr`=1 and `bus_size` are decoded from the strobe:
  - 1111: size 2, low address bits 00.
  - 0011 / 1100: size 1, low address bits 00 / 10.
  - Single bit n: size 0, low address bits = n.
  - Any other strobe: treat as size 2 with the given `wstrb`.
- `bus_addr` = {`ram_addr`[31:2], decoded low bits}.
- `ram_read_data` loads `bus_rdata` on a read's `data_ok`, or `ERR_DATA` on a read timeout. It holds until the next read completion and is never loaded by writes.
- Timeout counter:
  - Cleared in IDLE; increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT` without `data_ok`: go to DONE, `bus_error`=1 for that transition's following cycle (the DONE cycle), and drop `bus_req`.
- `data_ok` in IDLE or DONE is ignored; a late response after a timeout is discarded.
- Reset values: state IDLE, `ram_read_data`=0, counter 0, `bus_error`=0. `bus_req`/`stall` follow `ram_en` combinationally from IDLE.
- Reset mid-transaction: abort immediately to IDLE; any pending `data_ok` is dropped.

## Timing
- Best case (`addr_ok` & `data_ok` in the request cycle): stall for 1 cycle, core advances in cycle 2.
- General case: stall cycles = cycles until `data_ok` + 1.
- `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata` and `bus_wstrb` are stable from request until `addr_ok`.
- No combinational path from `bus_rdata` to `ram_read_data`.
- Combinational paths: `ram_en` → `stall`/`bus_req`; `bus_addr_ok` does not reach `stall` in the same cycle.

## Structure
- Package `ram_bus_pkg`:
  - state enum (IDLE/REQ/WAIT/DONE);
  - size encodings `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`;
  - the default `ERR_DATA`;
  - widths taken from the existing `ADDR_BUS`/`DATA_BUS`/`MEM_SEL_BUS` definitions.
- One sub-module, `ram_strobe_decode`: combinational `wstrb` → {`size`, `addr_lo`}.
- FSM, counter and data register live in `ram_bus_bridge`.

## Test plan
- Word read @0x100, `addr_ok`=`data_ok`=1 same cycle, `rdata`=0x12345678 → `stall` high 1 cycle, DONE next, `ram_read_data`=0x12345678, `bus_addr`=0x100, `bus_size`=2.
- Byte store `wstrb`=0100 @0x203, `addr_ok` after 2 cycles, `data_ok` 3 cycles later → `bus_addr`=0x202, `bus_size`=0, `bus_req` high 3 cycles, `stall` high 6 cycles, `ram_read_data` unchanged.
- Half store `wstrb`=1100 → `bus_size`=1, `bus_addr`[1:0]=10; `wstrb`=0011 → `bus_addr`[1:0]=00.
- `TIMEOUT`=4, read, never `data_ok` → DONE after 4 wait cycles, `bus_error` pulse of 1 cycle, `ram_read_data`=0xDEADBEEF; a later stray `data_ok` in IDLE changes nothing.
- Back-to-back reads with `ram_en` held high → IDLE between accesses, two distinct `bus_req` assertions, second data replaces first.
- `rst` asserted in WAIT → state IDLE and `bus_req`=0 asynchronously; `data_ok` arriving after release is ignored; a fresh read completes normally.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the core data-RAM to split-handshake bus bridge.
package ram_bus_pkg;

    localparam int ADDR_BUS    = 32;
    localparam int DATA_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [DATA_BUS-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ram_strobe_decode.sv
// Maps a store byte-strobe onto a bus transfer size and the low two address bits.
module ram_strobe_decode
    import ram_bus_pkg::*;
(
    input  logic [MEM_SEL_BUS-1:0] wstrb_i,
    output logic [1:0]             size_o,
    output logic [1:0]             addr_lo_o
);

    always_comb begin
        size_o    = SIZE_WORD;
        addr_lo_o = 2'b00;
        // Reads (strobe 0) and irregular strobes fall through as aligned words.
        case (wstrb_i)
            4'b0011: begin size_o = SIZE_HALF; addr_lo_o = 2'b00; end
            4'b1100: begin size_o = SIZE_HALF; addr_lo_o = 2'b10; end
            4'b0001: begin size_o = SIZE_BYTE; addr_lo_o = 2'b00; end
            4'b0010: begin size_o = SIZE_BYTE; addr_lo_o = 2'b01; end
            4'b0100: begin size_o = SIZE_BYTE; addr_lo_o = 2'b10; end
            4'b1000: begin size_o = SIZE_BYTE; addr_lo_o = 2'b11; end
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_bus_bridge.sv
// Turns the core's single-cycle data-RAM port into a split addr/data handshake bus,
// stalling the core until the access completes or a timeout forces completion.
//
// state | meaning
// IDLE  | no access outstanding; a new ram_en request is presented combinationally
// REQ   | request presented, waiting for bus_addr_ok
// WAIT  | request accepted, waiting for bus_data_ok
// DONE  | one-cycle completion; the only cycle the core advances past the access
module ram_bus_bridge
    import ram_bus_pkg::*;
#(
    parameter int unsigned          TIMEOUT  = 255,
    parameter logic [DATA_BUS-1:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ram_en,
    input  logic [MEM_SEL_BUS-1:0] ram_write_en,
    input  logic [ADDR_BUS-1:0]    ram_addr,
    input  logic [DATA_BUS-1:0]    ram_write_data,
    output logic [DATA_BUS-1:0]    ram_read_data,
    output logic                   stall,
    output logic                   bus_req,
    output logic                   bus_wr,
    output logic [1:0]             bus_size,
    output logic [MEM_SEL_BUS-1:0] bus_wstrb,
    output logic [ADDR_BUS-1:0]    bus_addr,
    output logic [DATA_BUS-1:0]    bus_wdata,
    input  logic                   bus_addr_ok,
    input  logic                   bus_data_ok,
    input  logic [DATA_BUS-1:0]    bus_rdata,
    output logic                   bus_error
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [DATA_BUS-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [1:0]          addr_lo;
    logic                is_read;
    logic                timeout;
    logic                unused_addr_lo;

    ram_strobe_decode u_decode (
        .wstrb_i   (ram_write_en),
        .size_o    (bus_size),
        .addr_lo_o (addr_lo)
    );

    // Core holds its request fields stable while stalled, so the bus fields pass straight through.
    assign bus_wr         = |ram_write_en;
    assign bus_wstrb      = ram_write_en;
    assign bus_wdata      = ram_write_data;
    assign bus_addr       = {ram_addr[ADDR_BUS-1:2], addr_lo};
    assign unused_addr_lo = ^ram_addr[1:0];

    assign is_read       = (ram_write_en == '0);
    assign timeout       = (cnt_q == CNT_LAST);
    assign stall         = ram_en && (state_q != ST_DONE);
    assign ram_read_data = rdata_q;
    assign bus_error     = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        bus_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ram_en) begin
                    bus_req = 1'b1;
                    if (bus_addr_ok && bus_data_ok) begin
                        state_d = ST_DONE;
                        if (is_read) rdata_d = bus_rdata;
                    end else if (bus_addr_ok) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                bus_req = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                if (bus_addr_ok && bus_data_ok) begin
                    state_d = ST_DONE;
                    if (is_read) rdata_d = bus_rdata;
                end else if (timeout) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (is_read) rdata_d = ERR_DATA;
                end else if (bus_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_data_ok) begin
                    state_d = ST_DONE;
                    if (is_read) rdata_d = bus_rdata;
                end else if (timeout) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (is_read) rdata_d = ERR_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
